// File: rtl/mac_tile_pkg.sv
// rtl/mac_tile_pkg.sv - shared state type and accumulator arithmetic for the MAC tile engine
package mac_tile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Wide signed container; accumulators up to 62 bits fit without overflow in the sum.
    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        calc_t sum;
        logic  ovf;
    } sat_res_t;

    function automatic calc_t acc_max(input int acc_w);
        return (calc_t'(1) <<< (acc_w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t acc_min(input int acc_w);
        return -(calc_t'(1) <<< (acc_w - 1));
    endfunction

    function automatic sat_res_t sat_add(input calc_t acc, input calc_t prod,
                                         input int acc_w, input logic sat);
        sat_res_t r;
        calc_t    s;
        s     = acc + prod;
        r.ovf = (s > acc_max(acc_w)) || (s < acc_min(acc_w));
        if (!r.ovf) begin
            r.sum = s;
        end else if (sat) begin
            r.sum = (s > acc_max(acc_w)) ? acc_max(acc_w) : acc_min(acc_w);
        end else begin
            r.sum = (s <<< (CALC_W - acc_w)) >>> (CALC_W - acc_w);
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one signed multiply-accumulate lane with saturate/wrap and sticky overflow
module mac_lane
    import mac_tile_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 16,
    parameter int SAT   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic signed [W-1:0]     a_i,
    input  logic signed [W-1:0]     w_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic                    ovf_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic signed [2*W-1:0]   prod;
    sat_res_t                res;
    logic                    unused_hi;

    assign prod = a_i * w_i;

    always_comb begin
        res   = sat_add(calc_t'(acc_q), calc_t'(prod), ACC_W, SAT != 0);
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            acc_d = res.sum[ACC_W-1:0];
            ovf_d = ovf_q | res.ovf;
        end
    end

    // Upper container bits are pure sign copies of the kept result.
    assign unused_hi = ^res.sum[CALC_W-1:ACC_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_tile_engine.sv
// rtl/mac_tile_engine.sv - N-lane signed dot-product engine with run sequencer and serial result drain
module mac_tile_engine
    import mac_tile_pkg::*;
#(
    parameter int W      = 8,
    parameter int ACC_W  = 16,
    parameter int N_MACS = 4,
    parameter int K_MAX  = 16,
    parameter int SAT    = 1,
    parameter int KW     = $clog2(K_MAX + 1),
    parameter int LW     = (N_MACS > 1) ? $clog2(N_MACS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [KW-1:0]           k_len_i,
    input  logic                    abort_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic signed [W-1:0]     a_data_i,
    input  logic [N_MACS*W-1:0]     w_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic signed [ACC_W-1:0] out_data_o,
    output logic [LW-1:0]           out_lane_o,
    output logic                    out_ovf_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    state_e                  state_q, state_d;
    logic [KW-1:0]           klen_q, klen_d;
    logic [KW-1:0]           cnt_q, cnt_d;
    logic [LW-1:0]           lane_q, lane_d;
    logic                    done_q, done_d;
    logic                    start_ok, accept, beat, out_hs, lane_last;
    logic signed [ACC_W-1:0] acc_arr [N_MACS];
    logic [N_MACS-1:0]       ovf_arr;

    assign start_ok  = start_i && !abort_i && (k_len_i != '0) && (k_len_i <= KW'(K_MAX));
    assign accept    = (state_q == ST_IDLE) && start_ok;
    assign beat      = in_ready_o && in_valid_i && !abort_i;
    assign out_hs    = out_valid_o && out_ready_i && !abort_i;
    assign lane_last = (lane_q == LW'(N_MACS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_ACCUM;
            ST_ACCUM: if (beat && (cnt_q == klen_q - KW'(1))) state_d = ST_DRAIN;
            ST_DRAIN: if (out_hs && lane_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    // Handshake-side outputs depend on the registered state alone.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = (state_q != ST_IDLE);
        case (state_q)
            ST_ACCUM: in_ready_o  = 1'b1;
            ST_DRAIN: out_valid_o = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        klen_d = klen_q;
        cnt_d  = cnt_q;
        lane_d = lane_q;
        done_d = (state_q == ST_DRAIN) && out_hs && lane_last;
        if (accept) begin
            klen_d = k_len_i;
            cnt_d  = '0;
            lane_d = '0;
        end else begin
            if (beat)   cnt_d  = cnt_q + KW'(1);
            if (out_hs) lane_d = lane_q + LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            klen_q <= '0;
            cnt_q  <= '0;
            lane_q <= '0;
            done_q <= 1'b0;
        end else begin
            klen_q <= klen_d;
            cnt_q  <= cnt_d;
            lane_q <= lane_d;
            done_q <= done_d;
        end
    end

    for (genvar i = 0; i < N_MACS; i++) begin : g_lane
        mac_lane #(
            .W     (W),
            .ACC_W (ACC_W),
            .SAT   (SAT)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (accept),
            .en_i    (beat),
            .a_i     (a_data_i),
            .w_i     (w_data_i[i*W +: W]),
            .acc_o   (acc_arr[i]),
            .ovf_o   (ovf_arr[i])
        );
    end

    // Result fields read as zero outside DRAIN so the port is quiet when idle.
    assign out_data_o = out_valid_o ? acc_arr[lane_q] : '0;
    assign out_lane_o = out_valid_o ? lane_q : '0;
    assign out_ovf_o  = out_valid_o && ovf_arr[lane_q];
    assign out_last_o = out_valid_o && lane_last;
    assign done_o     = done_q;

endmodule

// File: tb/tb_mac_tile_engine.sv
// tb/tb_mac_tile_engine.sv - randomized self-checking bench for mac_tile_engine against a behavioural model
module tb_mac_tile_engine;

    localparam int W = 8, ACC_W = 16, N = 4, K_MAX = 16, KW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start, abort, in_valid, out_ready;
    logic [KW-1:0] k_len;
    logic signed [W-1:0] a_data;
    logic [N*W-1:0] w_data;
    logic in_ready, out_valid, out_ovf, out_last, busy, done;
    logic signed [ACC_W-1:0] out_data;
    logic [1:0] out_lane;
    logic in_ready_w, out_valid_w, out_ovf_w, out_last_w, busy_w, done_w;
    logic signed [ACC_W-1:0] out_data_w;
    logic [1:0] out_lane_w;

    mac_tile_engine #(.W(W), .ACC_W(ACC_W), .N_MACS(N), .K_MAX(K_MAX), .SAT(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .k_len_i(k_len), .abort_i(abort),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .a_data_i(a_data), .w_data_i(w_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_lane_o(out_lane), .out_ovf_o(out_ovf), .out_last_o(out_last),
        .busy_o(busy), .done_o(done));

    mac_tile_engine #(.W(W), .ACC_W(ACC_W), .N_MACS(N), .K_MAX(K_MAX), .SAT(0)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .k_len_i(k_len), .abort_i(abort),
        .in_valid_i(in_valid), .in_ready_o(in_ready_w), .a_data_i(a_data), .w_data_i(w_data),
        .out_valid_o(out_valid_w), .out_ready_i(out_ready), .out_data_o(out_data_w),
        .out_lane_o(out_lane_w), .out_ovf_o(out_ovf_w), .out_last_o(out_last_w),
        .busy_o(busy_w), .done_o(done_w));

    int pass_cnt = 0, total_cnt = 0;
    int done_cnt = 0, ov_cnt = 0;

    logic signed [W-1:0] a_q [K_MAX];
    logic signed [W-1:0] w_q [K_MAX][N];

    longint res_data [N], res_data_w [N];
    logic   res_ovf [N], res_ovf_w [N], res_last [N];
    logic [1:0] res_lane [N];
    int  stall_err, latency;
    bit  timeout, start_seen, done_seen, idle_after;

    always @(negedge clk) begin
        done_cnt = done_cnt + int'(done);
        ov_cnt   = ov_cnt + int'(out_valid);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic longint model(input int l, input int k, input bit sat, output bit ovf);
        longint acc, mx, mn, span;
        span = longint'(1) << ACC_W;
        mx = span / 2 - 1;
        mn = -(span / 2);
        acc = 0;
        ovf = 1'b0;
        for (int b = 0; b < k; b++) begin
            acc += longint'(a_q[b]) * longint'(w_q[b][l]);
            if (acc > mx) begin ovf = 1'b1; acc = sat ? mx : acc - span; end
            else if (acc < mn) begin ovf = 1'b1; acc = sat ? mn : acc + span; end
        end
        return acc;
    endfunction

    task automatic fill_basic();
        for (int b = 0; b < K_MAX; b++) begin
            a_q[b] = W'(b + 1);
            for (int l = 0; l < N; l++) w_q[b][l] = W'(l + 1);
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < K_MAX; b++) begin
            a_q[b] = W'($urandom);
            for (int l = 0; l < N; l++) w_q[b][l] = W'($urandom);
        end
    endtask

    // Drives one whole run starting at the current negedge; returns at the negedge after the final drain handshake.
    task automatic run_job(input int k, input bit gaps, input bit bp, input bit poke);
        int idx, n, guard;
        bit acc, hold;
        logic signed [ACC_W-1:0] snap_d;
        logic [1:0] snap_l;
        logic snap_o, snap_t;
        time t0, t1;
        stall_err = 0; timeout = 1'b0; hold = 1'b0; t1 = 0;
        start = 1'b1; k_len = KW'(k); t0 = $time;
        @(negedge clk);
        start = 1'b0;
        start_seen = busy && in_ready && !done;
        idx = 0; guard = 0;
        while (idx < k && guard < 2000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            a_data = a_q[idx];
            for (int l = 0; l < N; l++) w_data[l*W +: W] = w_q[idx][l];
            if (poke) begin
                start = 1'($urandom_range(0, 1));
                k_len = KW'($urandom_range(1, K_MAX));
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            guard++;
            if (acc) idx++;
        end
        in_valid = 1'b0; start = 1'b0;
        if (idx < k) timeout = 1'b1;
        n = 0; guard = 0;
        while (n < N && guard < 2000 && !timeout) begin
            if (hold && (!out_valid || out_data !== snap_d || out_lane !== snap_l ||
                         out_ovf !== snap_o || out_last !== snap_t)) stall_err++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                res_data[n] = longint'(out_data);   res_ovf[n] = out_ovf;
                res_data_w[n] = longint'(out_data_w); res_ovf_w[n] = out_ovf_w;
                res_lane[n] = out_lane; res_last[n] = out_last;
                n++; hold = 1'b0; t1 = $time;
            end else if (out_valid) begin
                hold = 1'b1;
                snap_d = out_data; snap_l = out_lane; snap_o = out_ovf; snap_t = out_last;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        if (n < N) timeout = 1'b1;
        done_seen = done;
        idle_after = !busy && !out_valid;
        latency = int'((t1 - t0) / 10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({in_ready, out_valid, busy, done, out_ovf, out_last} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {in_ready, out_valid, busy, done, out_ovf, out_last});
        else pass_cnt++;
        total_cnt++;
        if (out_data !== '0 || out_lane !== '0)
            $display("FAIL reset_data: got data %0d lane %0d want 0 0", out_data, out_lane);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int d0;
        fill_basic();
        d0 = done_cnt;
        run_job(3, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (timeout) $display("FAIL basic_timeout: got 1 want 0"); else pass_cnt++;
        for (int n = 0; n < N; n++) begin
            total_cnt++;
            if (res_lane[n] !== 2'(n) || res_last[n] !== (n == N - 1))
                $display("FAIL basic_lane %0d: got lane %0d last %b want %0d %b", n, res_lane[n], res_last[n], n, n == N - 1);
            else pass_cnt++;
            total_cnt++;
            if (res_data[n] !== longint'(6 * (n + 1)) || res_ovf[n] !== 1'b0)
                $display("FAIL basic_data lane %0d: got %0d ovf %b want %0d ovf 0", n, res_data[n], res_ovf[n], 6 * (n + 1));
            else pass_cnt++;
        end
        total_cnt++;
        if (!start_seen) $display("FAIL basic_start: got busy %b in_ready %b want 1 1 after start", busy, in_ready); else pass_cnt++;
        total_cnt++;
        if (!done_seen || !idle_after) $display("FAIL basic_done: got done %b idle %b want 1 1", done_seen, idle_after); else pass_cnt++;
        total_cnt++;
        if (latency !== 3 + N) $display("FAIL basic_latency: got %0d want %0d", latency, 3 + N); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || done_cnt - d0 !== 1)
            $display("FAIL basic_done_pulse: got done %b count %0d want 0 1", done, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        bit ov;
        longint e;
        fill_random();
        for (int b = 0; b < 4; b++) begin a_q[b] = 8'sd127; w_q[b][0] = 8'sd127; w_q[b][1] = -8'sd128; end
        run_job(4, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (res_data[0] !== 32767 || res_ovf[0] !== 1'b1)
            $display("FAIL sat_lane0: got %0d ovf %b want 32767 ovf 1", res_data[0], res_ovf[0]);
        else pass_cnt++;
        total_cnt++;
        if (res_data[1] !== -32768 || res_ovf[1] !== 1'b1)
            $display("FAIL sat_lane1: got %0d ovf %b want -32768 ovf 1", res_data[1], res_ovf[1]);
        else pass_cnt++;
        total_cnt++;
        if (res_data_w[0] !== -1020 || res_ovf_w[0] !== 1'b1)
            $display("FAIL wrap_lane0: got %0d ovf %b want -1020 ovf 1", res_data_w[0], res_ovf_w[0]);
        else pass_cnt++;
        for (int l = 0; l < N; l++) begin
            e = model(l, 4, 1'b0, ov);
            total_cnt++;
            if (res_data_w[l] !== e || res_ovf_w[l] !== ov)
                $display("FAIL wrap_model lane %0d: got %0d ovf %b want %0d ovf %b", l, res_data_w[l], res_ovf_w[l], e, ov);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        fill_basic();
        run_job(3, 1'b1, 1'b1, 1'b0);
        total_cnt++;
        if (timeout || stall_err !== 0)
            $display("FAIL bp_stall: got timeout %b unstable %0d want 0 0", timeout, stall_err);
        else pass_cnt++;
        for (int n = 0; n < N; n++) begin
            total_cnt++;
            if (res_data[n] !== longint'(6 * (n + 1)) || res_lane[n] !== 2'(n))
                $display("FAIL bp_data lane %0d: got %0d at lane %0d want %0d", n, res_data[n], res_lane[n], 6 * (n + 1));
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int k, bad;
        bit ov, ovw, g, p;
        longint e, ew;
        for (int it = 0; it < 8; it++) begin
            fill_random();
            k = (it == 0) ? K_MAX : (it == 1) ? 1 : $urandom_range(1, K_MAX);
            g = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 1));
            run_job(k, g, 1'($urandom_range(0, 1)), p);
            bad = 0;
            for (int l = 0; l < N; l++) begin
                e  = model(l, k, 1'b1, ov);
                ew = model(l, k, 1'b0, ovw);
                if (res_data[l] !== e || res_ovf[l] !== ov || res_data_w[l] !== ew || res_ovf_w[l] !== ovw) begin
                    bad++;
                    $display("FAIL rand_data it %0d lane %0d k %0d: got %0d/%b wrap %0d/%b want %0d/%b wrap %0d/%b",
                             it, l, k, res_data[l], res_ovf[l], res_data_w[l], res_ovf_w[l], e, ov, ew, ovw);
                end
            end
            total_cnt++;
            if (bad == 0) pass_cnt++;
            total_cnt++;
            if (timeout || stall_err !== 0 || !done_seen)
                $display("FAIL rand_flow it %0d: got timeout %b unstable %0d done %b want 0 0 1", it, timeout, stall_err, done_seen);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ov;
        longint e;
        fill_basic();
        run_job(2, 1'b0, 1'b0, 1'b0);
        fill_random();
        run_job(5, 1'b0, 1'b0, 1'b0);
        total_cnt++;
        if (!start_seen) $display("FAIL b2b_start: got busy %b in_ready %b done %b want 1 1 0", busy, in_ready, done); else pass_cnt++;
        for (int l = 0; l < N; l++) begin
            e = model(l, 5, 1'b1, ov);
            total_cnt++;
            if (res_data[l] !== e || res_ovf[l] !== ov)
                $display("FAIL b2b_data lane %0d: got %0d ovf %b want %0d ovf %b", l, res_data[l], res_ovf[l], e, ov);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_rejects();
        int kv [2];
        kv[0] = 0; kv[1] = K_MAX + 1;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; k_len = KW'(kv[i]);
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            total_cnt++;
            if (busy !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL reject_k%0d: got busy %b in_ready %b want 0 0", kv[i], busy, in_ready);
            else pass_cnt++;
        end
        fill_basic();
        run_job(3, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < N; n++) begin
            total_cnt++;
            if (res_data[n] !== longint'(6 * (n + 1)))
                $display("FAIL reject_poke lane %0d: got %0d want %0d", n, res_data[n], 6 * (n + 1));
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int d0, v0;
        start = 1'b1; k_len = KW'(5);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; a_data = 8'sd127; w_data = {N{8'sd127}};
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL abort_idle: got busy %b in_ready %b out_valid %b want 0 0 0", busy, in_ready, out_valid);
        else pass_cnt++;
        d0 = done_cnt; v0 = ov_cnt;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (done_cnt !== d0 || ov_cnt !== v0)
            $display("FAIL abort_quiet: got done %0d valid %0d want 0 0", done_cnt - d0, ov_cnt - v0);
        else pass_cnt++;
        a_q[0] = 8'sd2;
        for (int l = 0; l < N; l++) w_q[0][l] = 8'sd3;
        run_job(1, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < N; l++) begin
            total_cnt++;
            if (res_data[l] !== 6 || res_ovf[l] !== 1'b0)
                $display("FAIL abort_rerun lane %0d: got %0d ovf %b want 6 ovf 0", l, res_data[l], res_ovf[l]);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_drain();
        fill_basic();
        start = 1'b1; k_len = KW'(3);
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; a_data = a_q[b];
            for (int l = 0; l < N; l++) w_data[l*W +: W] = w_q[b][l];
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_lane !== 2'd1 || out_data !== 16'sd12)
            $display("FAIL rst_mid_pre: got valid %b lane %0d data %0d want 1 1 12", out_valid, out_lane, out_data);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, busy, done, in_ready, out_ovf, out_last} !== 6'b0 || out_data !== '0 || out_lane !== '0)
            $display("FAIL rst_mid_zero: got flags %b data %0d lane %0d want 0", {out_valid, busy, done, in_ready, out_ovf, out_last}, out_data, out_lane);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rst_mid_idle: got busy %b out_valid %b want 0 0", busy, out_valid);
        else pass_cnt++;
        run_job(3, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < N; n++) begin
            total_cnt++;
            if (res_data[n] !== longint'(6 * (n + 1)))
                $display("FAIL rst_mid_rerun lane %0d: got %0d want %0d", n, res_data[n], 6 * (n + 1));
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        k_len = '0; a_data = '0; w_data = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_rejects();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mac_tile_engine.md
# mac_tile_engine

Parametrised successor to the fixed four-lane MAC datapath: an N_MACS-lane signed dot-product engine with a self-contained sequencer. It accepts a run-length `k_len` at `start`, then streams `k_len` beats. Each beat carries one activation and one weight per lane. Lanes accumulate with optional saturation, and the per-lane results drain serially over a valid/ready port. It sits between the input/weight memory interfaces (upstream) and the layering/writeback logic (downstream).

## Interface
- `W`, default 8: signed activation/weight width.
- `ACC_W`, default 16: signed accumulator width; must be ≥ 2·W.
- `N_MACS`, default 4: lane count, ≥ 1.
- `K_MAX`, default 16: maximum dot-product length.
- `SAT`, default 1: 1 = saturate accumulators, 0 = two's-complement wrap.
- `KW`, derived = $clog2(K_MAX+1): width of `k_len`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled in IDLE only.
- `k_len`  in  KW  beats per run; latched at accepted start.
- `abort`  in  1  synchronous cancel, any state.
- `in_valid` / `in_ready`  in / out  1  input beat handshake.
- `a_data`  in  W  signed activation, shared by all lanes.
- `w_data`  in  N_MACS·W  signed weights; lane i = bits [i·W +: W].
- `out_valid` / `out_ready`  out / in  1  result handshake.
- `out_data`  out  ACC_W  signed lane result.
- `out_lane`  out  max(1,$clog2(N_MACS))  lane index of `out_data`.
- `out_ovf`  out  1  lane saturated/wrapped at least once this run.
- `out_last`  out  1  qualifies the final lane (N_MACS-1).
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at normal run completion.

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - `start` with 1 ≤ `k_len` ≤ K_MAX: latch `k_len`, zero all accumulators, ovf flags and beat counter; go to ACCUM.
  - Any other `k_len` value: `start` ignored.
- ACCUM:
  - `in_ready` = 1.
  - On each accepted beat, every lane does acc ← acc + sext(a_data·w_i) and the counter increments.
  - Accepting beat number `k_len` moves the engine to DRAIN.
- DRAIN:
  - `out_valid` = 1; `out_lane` counts 0..N_MACS-1; `out_data`/`out_ovf` come from that lane.
  - Each handshake advances the lane.
  - The handshake with `out_last` = 1 moves the engine to IDLE and pulses `done`.
- Arithmetic:
  - The product is a 2W-bit signed value, sign-extended to ACC_W+1 bits and summed.
  - SAT=1: result above 2^(ACC_W-1)-1 clamps to max; result below -2^(ACC_W-1) clamps to min; ovf set sticky.
  - SAT=0: low ACC_W bits kept; ovf set sticky on signed overflow.
- `start` while busy is ignored. `start` does not accept a beat in the same cycle, because `in_ready` = 0 in IDLE.
- `abort` has priority over all other inputs:
  - Next state is IDLE; no `done`; pending results are discarded.
  - A beat presented in the abort cycle is not accepted.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only; no combinational input→output paths.

## Timing
- All outputs reset to 0; state resets to IDLE.
- Reset asserted mid-run takes effect immediately; no run state survives it.
- Accepted `start` at edge t: ACCUM from t+1, and `in_ready` = 1 in that cycle.
- Throughput: 1 beat/cycle; `in_valid` gaps stall without loss.
- The last beat accepted at edge t gives `out_valid` = 1 from t+1.
- Under back-pressure, `out_data`, `out_lane`, `out_ovf` and `out_last` hold stable while `out_valid` & !`out_ready`.
- `done` is high for the one cycle after the final drain handshake, coincident with IDLE.
- Minimum run: 1 (start) + k_len + N_MACS cycles.
- A new `start` is accepted in the same cycle as `done`.

## Structure
- Package `mac_tile_pkg` holds:
  - state enum (IDLE/ACCUM/DRAIN);
  - ACC_MAX/ACC_MIN constant functions of ACC_W;
  - the saturating-add function.
- Sub-module `mac_lane`, one per lane via generate:
  - multiply, extended add, saturate/wrap, sticky ovf;
  - clear/enable inputs driven by the sequencer.
- The sequencer (FSM, beat counter, drain mux) lives in `mac_tile_engine`.

## Test plan
- **Basic run:** k_len=3, a=1,2,3, lane i weight = i+1 every beat → outputs 6,12,18,24 on lanes 0..3; `out_last` on lane 3; `done` one cycle; ovf all 0.
- **Saturation:** SAT=1, k_len=4, a=127, lane0 w=127, lane1 w=-128.
  - Lane0 = 32767 with ovf=1; lane1 = -32768 with ovf=1.
  - SAT=0 rerun: lane0 = -1020 (64516 wrapped) with ovf=1.
- **Back-pressure:** random `in_valid` gaps and toggling `out_ready` → same results as the basic run; outputs stable while stalled; no beat lost or duplicated.
- **Rejects:** `start` with k_len=0 or k_len=K_MAX+1 → stays IDLE, `busy`=0. `start` pulsed during ACCUM → no effect on the result.
- **Abort:** abort after 2 beats → IDLE next cycle, no `out_valid`, no `done`. Following k_len=1 run with a=2, w=3 → all lanes output 6 (accumulators cleared).
- **Reset mid-DRAIN:** assert `rst` low mid-DRAIN → all outputs 0 immediately. After release, a fresh run produces correct results.
